// File: rtl/mem_arb_types.sv
// Shared types for the split inst/data memory arbiter.
package mem_arb_types;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INST,
    S_DRD,
    S_DWR,
    S_RESP_I,
    S_RESP_D
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } grant_t;

  localparam logic [3:0] PMEM_READ_MBE = 4'hF;

endpackage

// File: rtl/arb_grant.sv
// Combinational inst/data picker: fixed data priority or round-robin.
module arb_grant
  import mem_arb_types::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic   inst_pend,
  input  logic   data_pend,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   grant_vld
);

  always_comb begin
    grant_vld = inst_pend | data_pend;
    grant     = DATA;
    if (inst_pend && data_pend) begin
      // Round-robin hands the tie to whoever did not win last time.
      if (DATA_PRIORITY == 0 && last_grant == DATA) grant = INST;
    end else if (inst_pend) begin
      grant = INST;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises core inst/data requests onto one shared pmem port.
module core_mem_arbiter
  import mem_arb_types::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic        inst_resp,
  output logic [31:0] inst_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mbe,
  output logic        data_resp,
  output logic [31:0] data_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_mbe,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);

  arb_state_t  state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  grant_t gnt;
  logic   gnt_vld;

  arb_grant #(.DATA_PRIORITY(DATA_PRIORITY)) u_grant (
    .inst_pend  (inst_read),
    .data_pend  (data_read | data_write),
    .last_grant (last_grant_q),
    .grant      (gnt),
    .grant_vld  (gnt_vld)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mbe_d        = mbe_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          last_grant_d = gnt;
          if (gnt == INST) begin
            addr_d  = inst_addr;
            state_d = S_INST;
          end else begin
            addr_d  = data_addr;
            wdata_d = data_wdata;
            mbe_d   = data_mbe;
            // Read and write together resolve to a store.
            state_d = data_write ? S_DWR : S_DRD;
          end
        end
      end
      S_INST: begin
        if (pmem_resp) begin
          inst_rdata_d = pmem_rdata;
          state_d      = S_RESP_I;
        end
      end
      S_DRD: begin
        if (pmem_resp) begin
          data_rdata_d = pmem_rdata;
          state_d      = S_RESP_D;
        end
      end
      S_DWR: begin
        if (pmem_resp) state_d = S_RESP_D;
      end
      S_RESP_I, S_RESP_D: state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= DATA;
      addr_q       <= '0;
      wdata_q      <= '0;
      mbe_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mbe_q        <= mbe_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    pmem_read    = (state_q == S_INST) || (state_q == S_DRD);
    pmem_write   = (state_q == S_DWR);
    pmem_address = addr_q & 32'hFFFF_FFFC;
    pmem_wdata   = wdata_q;
    pmem_mbe     = pmem_write ? mbe_q : (pmem_read ? PMEM_READ_MBE : 4'h0);
    inst_resp    = (state_q == S_RESP_I);
    data_resp    = (state_q == S_RESP_D);
    inst_rdata   = inst_rdata_q;
    data_rdata   = data_rdata_q;
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: priority and round-robin instances.
module tb_core_mem_arbiter;
  import mem_arb_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Data-priority instance
  logic        inst_read = 0, data_read = 0, data_write = 0, pmem_resp = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, pmem_rdata = 0;
  logic [3:0]  data_mbe = 0;
  logic        inst_resp, data_resp, pmem_read, pmem_write;
  logic [31:0] inst_rdata, data_rdata, pmem_address, pmem_wdata;
  logic [3:0]  pmem_mbe;

  // Round-robin instance
  logic        r_inst_read = 0, r_data_read = 0, r_data_write = 0, r_pmem_resp = 0;
  logic [31:0] r_inst_addr = 0, r_data_addr = 0, r_data_wdata = 0, r_pmem_rdata = 0;
  logic [3:0]  r_data_mbe = 0;
  logic        r_inst_resp, r_data_resp, r_pmem_read, r_pmem_write;
  logic [31:0] r_inst_rdata, r_data_rdata, r_pmem_address, r_pmem_wdata;
  logic [3:0]  r_pmem_mbe;

  int tests = 0;
  int fails = 0;

  core_mem_arbiter #(.DATA_PRIORITY(1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_resp(inst_resp), .inst_rdata(inst_rdata),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_mbe(data_mbe), .data_resp(data_resp), .data_rdata(data_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_mbe(pmem_mbe), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  core_mem_arbiter #(.DATA_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .inst_read(r_inst_read), .inst_addr(r_inst_addr), .inst_resp(r_inst_resp), .inst_rdata(r_inst_rdata),
    .data_read(r_data_read), .data_write(r_data_write), .data_addr(r_data_addr),
    .data_wdata(r_data_wdata), .data_mbe(r_data_mbe), .data_resp(r_data_resp), .data_rdata(r_data_rdata),
    .pmem_read(r_pmem_read), .pmem_write(r_pmem_write), .pmem_address(r_pmem_address),
    .pmem_wdata(r_pmem_wdata), .pmem_mbe(r_pmem_mbe), .pmem_resp(r_pmem_resp), .pmem_rdata(r_pmem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pmem_read || pmem_write) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL strobe_timeout: no pmem strobe within 20 cycles, required one");
    end
  endtask

  task automatic respond(input logic [31:0] rd);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    tick();
    pmem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({inst_resp, data_resp, pmem_read, pmem_write, inst_rdata, data_rdata, pmem_address, pmem_wdata, pmem_mbe} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    tests++;
    if ({r_inst_resp, r_data_resp, r_pmem_read, r_pmem_write, r_pmem_address, r_pmem_mbe} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_rr: got nonzero outputs, required all 0");
    end
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    bit ok;
    inst_read = 1'b1;
    inst_addr = 32'h6000_0003;
    wait_strobe(ok);
    tests++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h6000_0000 || pmem_mbe !== 4'hF) begin
      fails++;
      $display("FAIL fetch_strobe: rd=%b wr=%b addr=%h mbe=%h, required 1 0 60000000 f", pmem_read, pmem_write, pmem_address, pmem_mbe);
    end
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (pmem_read !== 1'b1 || inst_resp !== 1'b0) begin
      fails++;
      $display("FAIL fetch_hold: rd=%b resp=%b, required 1 0", pmem_read, inst_resp);
    end
    respond(32'hDEAD_BEEF);
    tests++;
    if (inst_resp !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF || pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL fetch_resp: resp=%b rdata=%h rd=%b, required 1 deadbeef 0", inst_resp, inst_rdata, pmem_read);
    end
    inst_read = 1'b0;
    tick();
    tests++;
    if (inst_resp !== 1'b0 || inst_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL fetch_pulse: resp=%b rdata=%h, required 0 deadbeef", inst_resp, inst_rdata);
    end
  endtask

  task automatic test_contention_prio();
    bit ok;
    inst_read = 1'b1; inst_addr = 32'h0000_0300;
    data_read = 1'b1; data_addr = 32'h0000_0400;
    wait_strobe(ok);
    tests++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0400) begin
      fails++;
      $display("FAIL prio_first: rd=%b addr=%h, required 1 00000400", pmem_read, pmem_address);
    end
    respond(32'hA5A5_0001);
    tests++;
    if (data_resp !== 1'b1 || data_rdata !== 32'hA5A5_0001 || inst_resp !== 1'b0) begin
      fails++;
      $display("FAIL prio_data_resp: dresp=%b rdata=%h iresp=%b, required 1 a5a50001 0", data_resp, data_rdata, inst_resp);
    end
    data_read = 1'b0;
    tick();
    tests++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      fails++;
      $display("FAIL prio_dead_cycle: rd=%b wr=%b, required 0 0", pmem_read, pmem_write);
    end
    tick();
    tests++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0300) begin
      fails++;
      $display("FAIL prio_second: rd=%b addr=%h, required 1 00000300", pmem_read, pmem_address);
    end
    respond(32'h0BAD_F00D);
    tests++;
    if (inst_resp !== 1'b1 || inst_rdata !== 32'h0BAD_F00D || data_rdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL prio_inst_resp: resp=%b irdata=%h drdata=%h, required 1 0badf00d a5a50001", inst_resp, inst_rdata, data_rdata);
    end
    inst_read = 1'b0;
    tick();
  endtask

  task automatic test_store();
    bit ok;
    data_write = 1'b1;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'h1234_5678;
    data_mbe   = 4'h3;
    wait_strobe(ok);
    data_addr  = 32'hFFFF_FFF0;
    data_wdata = 32'h0;
    data_mbe   = 4'hC;
    tick();
    tests++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_0100 ||
        pmem_wdata !== 32'h1234_5678 || pmem_mbe !== 4'h3) begin
      fails++;
      $display("FAIL store_strobe: wr=%b rd=%b addr=%h wdata=%h mbe=%h, required 1 0 00000100 12345678 3",
               pmem_write, pmem_read, pmem_address, pmem_wdata, pmem_mbe);
    end
    respond(32'h7777_7777);
    tests++;
    if (data_resp !== 1'b1 || data_rdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL store_resp: resp=%b rdata=%h, required 1 a5a50001", data_resp, data_rdata);
    end
    data_write = 1'b0;
    tick();
    tests++;
    if (data_resp !== 1'b0) begin
      fails++;
      $display("FAIL store_pulse: resp=%b, required 0", data_resp);
    end
  endtask

  task automatic test_resp_outside();
    respond(32'h5555_AAAA);
    tests++;
    if (inst_resp !== 1'b0 || data_resp !== 1'b0 || inst_rdata !== 32'h0BAD_F00D || data_rdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL idle_resp_ignored: iresp=%b dresp=%b irdata=%h drdata=%h, required 0 0 0badf00d a5a50001",
               inst_resp, data_resp, inst_rdata, data_rdata);
    end
  endtask

  task automatic test_rd_wr_both();
    bit ok;
    int nresp = 0;
    data_read  = 1'b1;
    data_write = 1'b1;
    data_addr  = 32'h0000_0208;
    data_wdata = 32'hCAFE_0000;
    data_mbe   = 4'hF;
    wait_strobe(ok);
    tests++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL both_strobe: wr=%b rd=%b, required 1 0", pmem_write, pmem_read);
    end
    respond(32'h0);
    if (data_resp) nresp++;
    data_read  = 1'b0;
    data_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (data_resp) nresp++;
    end
    tests++;
    if (nresp != 1 || data_rdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL both_resp_count: resps=%0d rdata=%h, required 1 a5a50001", nresp, data_rdata);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int nresp = 0;
    data_read = 1'b1;
    data_addr = 32'h0000_0500;
    wait_strobe(ok);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({inst_resp, data_resp, pmem_read, pmem_write, inst_rdata, data_rdata, pmem_address, pmem_wdata, pmem_mbe} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: rd=%b drdata=%h addr=%h, required all outputs 0", pmem_read, data_rdata, pmem_address);
    end
    data_read = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h9999_9999;
    tick();
    pmem_resp = 1'b0;
    if (data_resp) nresp++;
    tests++;
    if (u_dut.state_q !== S_IDLE || pmem_read !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_state: state=%0d rd=%b, required IDLE 0", u_dut.state_q, pmem_read);
    end
    tick();
    if (data_resp) nresp++;
    tests++;
    if (nresp != 0 || data_rdata !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset_no_resp: resps=%0d rdata=%h, required 0 00000000", nresp, data_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h0000_1000; exp_addr[1] = 32'h0000_2000;
    exp_addr[2] = 32'h0000_1000; exp_addr[3] = 32'h0000_2000;
    r_inst_read = 1'b1; r_inst_addr = 32'h0000_1000;
    r_data_read = 1'b1; r_data_addr = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (r_pmem_read) begin
          seen = 1'b1;
          break;
        end
      end
      tests++;
      if (!seen || r_pmem_address !== exp_addr[t]) begin
        fails++;
        $display("FAIL rr_grant%0d: strobe=%b addr=%h, required 1 %h", t, seen, r_pmem_address, exp_addr[t]);
      end
      r_pmem_resp  = 1'b1;
      r_pmem_rdata = 32'h0000_00A0 + t;
      tick();
      r_pmem_resp  = 1'b0;
      tests++;
      if ((t % 2 == 0) ? (r_inst_resp !== 1'b1 || r_data_resp !== 1'b0 || r_inst_rdata !== 32'h0000_00A0 + t)
                       : (r_data_resp !== 1'b1 || r_inst_resp !== 1'b0 || r_data_rdata !== 32'h0000_00A0 + t)) begin
        fails++;
        $display("FAIL rr_resp%0d: iresp=%b dresp=%b irdata=%h drdata=%h, required slot %0d rdata %h",
                 t, r_inst_resp, r_data_resp, r_inst_rdata, r_data_rdata, t % 2, 32'h0000_00A0 + t);
      end
    end
    r_inst_read = 1'b0;
    r_data_read = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention_prio();
    test_store();
    test_resp_outside();
    test_rd_wr_both();
    test_reset_mid_load();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
